// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: sequencing states and IEEE-754 double field constants shared by the fp_mult arbiter
package fp_mult_pkg;
    typedef enum logic [2:0] {IDLE, CLR, FEED, WAIT, COLLECT, RESP} state_t;
    localparam int OPERAND_BYTES = 8;
    localparam int FEED_BYTES = 16;
    localparam int RESULT_BYTES = 8;
    localparam int EXP_W = 11;
    localparam int FRAC_W = 52;
    localparam logic [EXP_W-1:0] EXP_ALL1 = 11'h7FF;
    localparam int DBL_W = 1 + EXP_W + FRAC_W;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching upward from a rotating pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);
    logic [ID_W-1:0] ptr;

    function automatic logic [ID_W-1:0] slot(input int i);
        return ID_W'((int'(ptr) + i) % NUM_REQ);
    endfunction

    // Scanning from the farthest slot down lets the nearest requester overwrite the others.
    always_comb begin
        grant = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[slot(i)]) begin
                grant = NUM_REQ'(1) << slot(i);
                idx = slot(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            ptr <= '0;
        else if (update)
            ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin front end that shares one byte-serial double multiplier between requesters
module fp_mult_arbiter
    import fp_mult_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W = 2,
    parameter int TIMEOUT = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [DBL_W*NUM_REQ-1:0] req_a,
    input  logic [DBL_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DBL_W-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     MUL_RESET,
    output logic                     MUL_ENABLE,
    output logic [7:0]               MUL_DATA_IN,
    input  logic [7:0]               MUL_DATA_OUT,
    input  logic                     MUL_READY
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t                        state, state_n;
    logic [NUM_REQ-1:0]            grant;
    logic [ID_W-1:0]               gidx;
    logic [DBL_W-1:0]              a_arr [NUM_REQ];
    logic [DBL_W-1:0]              b_arr [NUM_REQ];
    logic [2*8*OPERAND_BYTES-1:0]  ops;
    logic [3:0]                    cnt;
    logic [WAIT_W-1:0]             wcnt;
    logic                          take, feed_done, got_all, timed_out;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign a_arr[g] = req_a[g*DBL_W +: DBL_W];
        assign b_arr[g] = req_b[g*DBL_W +: DBL_W];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .CLK(CLK),
        .RESET(RESET),
        .req(req_valid),
        .update(take),
        .grant(grant),
        .idx(gidx)
    );

    assign take = state == IDLE && |req_valid && !RESET;
    assign req_ready = take ? grant : '0;
    assign rsp_valid = state == RESP;
    assign MUL_RESET = RESET || state == CLR;
    assign MUL_ENABLE = state == FEED;
    assign MUL_DATA_IN = MUL_ENABLE ? ops[2*8*OPERAND_BYTES-1 -: 8] : 8'h00;
    assign feed_done = cnt == 4'(FEED_BYTES - 1);
    assign got_all = cnt == 4'(RESULT_BYTES - 1);
    assign timed_out = wcnt == WAIT_W'(TIMEOUT - 1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = take ? CLR : IDLE;
            CLR:     state_n = FEED;
            FEED:    state_n = feed_done ? WAIT : FEED;
            WAIT:    state_n = MUL_READY ? COLLECT : timed_out ? RESP : WAIT;
            COLLECT: state_n = (!MUL_READY || got_all) ? RESP : COLLECT;
            RESP:    state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) state <= RESET ? IDLE : state_n;

    // rsp_data doubles as the collect shift register; a short or missing result zeroes it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ops <= '0;
            cnt <= '0;
            wcnt <= '0;
            rsp_id <= '0;
            rsp_data <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    ops <= {a_arr[gidx], b_arr[gidx]};
                    rsp_id <= gidx;
                end
                CLR: cnt <= '0;
                FEED: begin
                    ops <= ops << 8;
                    cnt <= cnt + 4'd1;
                    wcnt <= '0;
                end
                WAIT: if (MUL_READY) begin
                    rsp_data <= {rsp_data[DBL_W-9:0], MUL_DATA_OUT};
                    cnt <= 4'd1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                    if (timed_out) begin
                        rsp_data <= '0;
                        rsp_err <= 1'b1;
                    end
                end
                COLLECT: if (MUL_READY) begin
                    rsp_data <= {rsp_data[DBL_W-9:0], MUL_DATA_OUT};
                    cnt <= cnt + 4'd1;
                    rsp_err <= 1'b0;
                end else begin
                    rsp_data <= '0;
                    rsp_err <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: directed and randomized checks against a behavioural multiplier and round-robin model
module tb_fp_mult_arbiter;
    import fp_mult_pkg::*;
    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [N-1:0] req_valid;
    logic [255:0] req_a, req_b;
    logic [N-1:0] req_ready;
    logic         rsp_valid, rsp_ready, rsp_err;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_data;
    logic         MUL_RESET, MUL_ENABLE;
    logic [7:0]   MUL_DATA_IN;
    logic [7:0]   MUL_DATA_OUT = 8'h00;
    logic         MUL_READY = 1'b0;

    int passed = 0, fails = 0, total = 0, rr_ptr = 0, clr_cnt = 0;
    logic [7:0] feed_q [$];
    bit stub_dead = 0;
    int nin = 0, dly = -1, nout = 0;
    logic [127:0] sh = '0;
    logic [63:0] prod = '0;

    always #5 CLK = ~CLK;

    fp_mult_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT(32)) dut (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .MUL_RESET(MUL_RESET), .MUL_ENABLE(MUL_ENABLE),
        .MUL_DATA_IN(MUL_DATA_IN), .MUL_DATA_OUT(MUL_DATA_OUT), .MUL_READY(MUL_READY)
    );

    function automatic logic is_nan(input logic [63:0] x);
        return x[62:52] == EXP_ALL1 && x[51:0] != 52'd0;
    endfunction

    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        if (is_nan(a) || is_nan(b)) return 64'h7FF8000000000000;
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    function automatic logic [63:0] rnd_op();
        return {1'($urandom), 11'($urandom_range(1046, 1000)), 20'($urandom), 32'($urandom)};
    endfunction

    // Multiplier stand-in: 16 bytes in, 11 compute cycles (3 for NaN), then 8 result bytes with READY.
    always @(posedge CLK) begin
        if (MUL_RESET) begin
            nin = 0; dly = -1; nout = 0;
            MUL_READY <= 1'b0; MUL_DATA_OUT <= 8'h00;
        end else if (MUL_ENABLE) begin
            sh = {sh[119:0], MUL_DATA_IN};
            nin++;
            if (nin == 16) begin
                prod = ref_mul(sh[127:64], sh[63:0]);
                dly = (is_nan(sh[127:64]) || is_nan(sh[63:0])) ? 3 : 11;
                nout = 0;
            end
        end else if (dly > 0) begin
            dly--;
        end else if (dly == 0 && !stub_dead) begin
            if (nout < 8) begin
                MUL_READY <= 1'b1; MUL_DATA_OUT <= prod[63-8*nout -: 8]; nout++;
            end else begin
                MUL_READY <= 1'b0; MUL_DATA_OUT <= 8'h00; dly = -1;
            end
        end
    end

    always @(negedge CLK) begin
        if (MUL_ENABLE) feed_q.push_back(MUL_DATA_IN);
        if (MUL_RESET && !RESET) clr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick();
        for (int i = 0; i < N; i++)
            if (req_valid[2'((rr_ptr + i) % N)]) return (rr_ptr + i) % N;
        return -1;
    endfunction

    task automatic serve(input string tag, input bit keep, input int stall, input bit exp_err,
                         output int g, output int lat, output logic [63:0] got);
        int n = 0;
        int p;
        logic [63:0] exp;
        logic [63:0] d0;
        logic [1:0] i0;
        bit quiet = 1;
        #1;
        while (req_ready == '0 && n < 50) begin tick(); n++; end
        p = rr_pick();
        check({tag, " grant"}, 128'(req_ready), p < 0 ? 128'(0) : 128'(1) << p);
        g = p < 0 ? 0 : p;
        exp = exp_err ? 64'd0 : ref_mul(req_a[g*64 +: 64], req_b[g*64 +: 64]);
        rr_ptr = (g + 1) % N;
        tick();
        if (keep) begin
            req_a[g*64 +: 64] = rnd_op();
            req_b[g*64 +: 64] = rnd_op();
        end else req_valid[g] = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 200) begin tick(); lat++; end
        check({tag, " id"}, 128'(rsp_id), 128'(g));
        check({tag, " data"}, 128'(rsp_data), 128'(exp));
        check({tag, " err"}, 128'(rsp_err), 128'(exp_err));
        got = rsp_data;
        d0 = rsp_data;
        i0 = rsp_id;
        for (int s = 0; s < stall; s++) begin
            tick();
            quiet &= rsp_valid === 1'b1 && rsp_data === d0 && rsp_id === i0 && req_ready === '0 && MUL_ENABLE === 1'b0;
        end
        if (stall > 0) check({tag, " stall"}, 128'(quiet), 128'(1));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " accept"}, 128'(rsp_valid), 128'(0));
    endtask

    initial begin
        int g, lat_norm, lat, n;
        logic [63:0] got, a3;
        logic [127:0] fb;
        logic [15:0] seq;
        bit seen;
        RESET = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) tick();
        check("rst req_ready", 128'(req_ready), 128'(0));
        check("rst rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst rsp_id", 128'(rsp_id), 128'(0));
        check("rst rsp_data", 128'(rsp_data), 128'(0));
        check("rst rsp_err", 128'(rsp_err), 128'(0));
        check("rst enable", 128'(MUL_ENABLE), 128'(0));
        check("rst data_in", 128'(MUL_DATA_IN), 128'(0));
        check("rst mul_reset", 128'(MUL_RESET), 128'(1));
        RESET = 1'b0;
        tick();
        check("idle mul_reset", 128'(MUL_RESET), 128'(0));

        feed_q.delete(); clr_cnt = 0;
        req_a[63:0] = 64'h3FF8000000000000; req_b[63:0] = 64'h4000000000000000; req_valid = 4'b0001;
        serve("mul", 0, 0, 0, g, lat_norm, got);
        check("mul product", 128'(got), 128'(64'h4008000000000000));
        check("mul latency", 128'(lat_norm), 128'(1 + 16 + 12 + 8));
        check("mul clr pulses", 128'(clr_cnt), 128'(1));
        check("mul feed count", 128'(feed_q.size()), 128'(16));
        fb = '0;
        foreach (feed_q[i]) fb = {fb[119:0], feed_q[i]};
        check("mul feed bytes", fb, 128'h3FF80000000000004000000000000000);

        req_a[191:128] = 64'h7FF8000000000000; req_b[191:128] = 64'h3FF0000000000000; req_valid = 4'b0100;
        serve("nan", 0, 0, 0, g, lat, got);
        check("nan product", 128'(got), 128'(64'h7FF8000000000000));
        check("nan shorter", 128'(lat < lat_norm), 128'(1));

        a3 = rnd_op();
        req_a[255:192] = a3; req_b[255:192] = rnd_op(); req_valid = 4'b1000;
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin tick(); n++; end
        check("midrst grant", 128'(req_ready), 128'(4'b1000));
        tick();
        req_valid = '0;
        repeat (8) tick();
        check("midrst byte7", 128'(MUL_DATA_IN), 128'(a3[7:0]));
        RESET = 1'b1;
        tick();
        check("midrst enable", 128'(MUL_ENABLE), 128'(0));
        check("midrst req_ready", 128'(req_ready), 128'(0));
        check("midrst rsp_valid", 128'(rsp_valid), 128'(0));
        check("midrst data_in", 128'(MUL_DATA_IN), 128'(0));
        RESET = 1'b0;
        rr_ptr = 0;
        seen = 0;
        repeat (60) begin tick(); seen |= rsp_valid === 1'b1; end
        check("midrst no rsp", 128'(seen), 128'(0));
        req_a[255:192] = rnd_op(); req_b[255:192] = rnd_op(); req_valid = 4'b1000;
        serve("p3", 0, 0, 0, g, lat, got);

        for (int i = 0; i < N; i++) begin
            req_a[i*64 +: 64] = rnd_op();
            req_b[i*64 +: 64] = rnd_op();
        end
        req_valid = 4'hF;
        seq = '0;
        for (int k = 0; k < 4; k++) begin
            serve("rr4", 1, k == 1 ? 5 : 0, 0, g, lat, got);
            seq = {seq[11:0], 4'(g)};
        end
        check("rr4 order", 128'(seq), 128'(16'h0123));
        req_valid[1] = 1'b0;
        seq = '0;
        for (int k = 0; k < 3; k++) begin
            serve("rr3", 1, 0, 0, g, lat, got);
            seq = {seq[11:0], 4'(g)};
        end
        check("rr3 order", 128'(seq), 128'(16'h0023));
        req_valid = '0;
        tick();

        stub_dead = 1;
        req_a[63:0] = rnd_op(); req_b[63:0] = rnd_op(); req_valid = 4'b0001;
        serve("timeout", 0, 0, 1, g, lat, got);
        check("timeout latency", 128'(lat), 128'(1 + 16 + 32));
        stub_dead = 0;
        req_a[127:64] = rnd_op(); req_b[127:64] = rnd_op(); req_valid = 4'b0010;
        serve("recover", 0, 0, 0, g, lat, got);
        check("recover latency", 128'(lat), 128'(lat_norm));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Round-robin scheduler that shares one byte-serial double-precision fp_mult instance between NUM_REQ requesters.
- Accepts a 64-bit operand pair from the granted requester and clears the multiplier.
- Streams the operands in as 16 bytes, collects the 8 result bytes, and returns the 64-bit product tagged with the requester id.
- Sits between the requester fabric and the fp_mult instance; the multiplier is instantiated at the parent level and wired to the MUL_* ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of rsp_id; equals clog2(NUM_REQ)
TIMEOUT, 32, maximum cycles in WAIT before the operation is aborted

Ports:
CLK  in  1  clock
RESET  in  1  reset; synchronous, active-high
req_valid  in  NUM_REQ  per-requester request
req_a  in  64*NUM_REQ  operand A, IEEE-754 double; slice i belongs to requester i
req_b  in  64*NUM_REQ  operand B, same layout
req_ready  out  NUM_REQ  one-hot, one-cycle grant pulse; operands are captured on this cycle
rsp_valid  out  1  response valid; held until accepted
rsp_ready  in  1  response accept
rsp_id  out  ID_W  index of the requester owning the response
rsp_data  out  64  product, IEEE-754 double
rsp_err  out  1  timeout flag; rsp_data is 0 when set
MUL_RESET  out  1  to fp_mult RESET
MUL_ENABLE  out  1  to fp_mult ENABLE
MUL_DATA_IN  out  8  to fp_mult DATA_IN
MUL_DATA_OUT  in  8  from fp_mult DATA_OUT
MUL_READY  in  1  from fp_mult READY

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, MUL_ENABLE=0, MUL_DATA_IN=0; round-robin pointer=0; state=IDLE.
- MUL_RESET = RESET OR (state==CLR). It is combinational from RESET; registered state otherwise.
- IDLE: when any req_valid is set, grant the lowest index >= pointer, wrapping around.
  - Pulse req_ready[g] for one cycle and latch A, B and g.
  - pointer <= (g+1) mod NUM_REQ.
  - Go to CLR.
- CLR: one cycle with MUL_RESET=1, then FEED. This cycle clears the multiplier's counters from the previous operation.
- FEED: 16 consecutive cycles with MUL_ENABLE=1 and byte counter k=0..15.
  - MUL_DATA_IN = A[63-8k -: 8] for k<8, then B[63-8(k-8) -: 8]; MSB byte first.
  - After k=15: MUL_ENABLE=0, wait counter cleared, go to WAIT.
- WAIT: increment the wait counter each cycle.
  - When MUL_READY=1, go to COLLECT and capture that first byte in the same cycle.
  - If the counter reaches TIMEOUT: rsp_err=1, rsp_data=0, go to RESP. This pulses MUL_RESET via CLR on the next operation.
- COLLECT: while MUL_READY=1, shift MUL_DATA_OUT into the result MSB-first. Byte 0 is {sign, exp[10:4]}.
  - After 8 bytes: rsp_data=result, rsp_err=0, go to RESP.
  - If MUL_READY drops before 8 bytes: treat as error, rsp_err=1, rsp_data=0.
- RESP: rsp_valid=1, with rsp_id, rsp_data and rsp_err stable.
  - On rsp_valid && rsp_ready: rsp_valid=0 next cycle, go to IDLE.
  - No new grant is issued in the same cycle as acceptance.
- Latency from grant to rsp_valid, normal operands: 1 (CLR) + 16 (FEED) + multiplier compute + 8 (COLLECT). The compute phase is 11 cycles max, fewer for special cases.
- Requests arriving or dropping outside IDLE are ignored. A requester must hold req_valid and operands until req_ready.
- req_valid deasserted in IDLE: no grant, pointer unchanged.
- RESET mid-operation (any state): all outputs return to reset values next cycle, the pointer returns to 0, and the latched operands are discarded with no response.

Decomposition:
- Shared package fp_mult_pkg holds:
  - state enum: IDLE, CLR, FEED, WAIT, COLLECT, RESP.
  - constants: OPERAND_BYTES=8, FEED_BYTES=16, RESULT_BYTES=8.
  - IEEE-754 double field constants: EXP_W=11, FRAC_W=52, EXP_ALL1=11'h7FF.
- One sub-module, rr_arbiter (NUM_REQ):
  - Combinational grant from request vector and pointer; outputs a one-hot grant and an index.
  - Pointer register with an update enable.

Test Plan:
- Single request on port 0 with A=0x3FF8000000000000 (1.5), B=0x4000000000000000 (2.0):
  - req_ready[0] pulses once, MUL_RESET high for 1 cycle, 16 MUL_ENABLE cycles with bytes 3F,F8,00×6,40,00×7.
  - Then rsp_valid, rsp_id=0, rsp_data=0x4008000000000000, rsp_err=0.
- NaN passthrough on port 2: A=0x7FF8000000000000, B=0x3FF0000000000000 -> rsp_data=0x7FF8000000000000, rsp_id=2; shorter WAIT than the normal case.
- All four req_valid held high with distinct operands:
  - Grant order 0,1,2,3; then with port 1 dropped, the next order is 0,2,3.
  - Every rsp_id matches its operands' expected products.
- rsp_ready held low for 5 cycles after rsp_valid: rsp_valid, rsp_data and rsp_id stay stable, and no req_ready or MUL_ENABLE occurs until acceptance.
- Multiplier stub that never raises MUL_READY: after 16 feed cycles plus TIMEOUT=32 cycles, rsp_valid=1, rsp_err=1, rsp_data=0; the next request still completes normally after CLR.
- RESET asserted on feed byte 7:
  - Next cycle MUL_ENABLE=0, req_ready=0, rsp_valid=0 and no response is issued.
  - A subsequent request from port 3 is granted and returns the correct product.
